// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   state_e : sequencer states (IDLE -> ACCESS -> DONE -> IDLE)
//   owner_e : which requester owns the current transaction
//   LAT_W   : width of the ACCESS latency down-counter
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    localparam int LAT_W = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker.
//   clk_i, rst_i  : clock, asynchronous active-low reset
//   cpu_req_i     : CPU candidate
//   dbg_req_i     : debug candidate
//   update_i      : a grant is being taken this cycle; remember its owner
//   gnt_valid_o   : at least one candidate present
//   gnt_o         : chosen owner (meaningful only when gnt_valid_o is high)
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   cpu_req_i,
    input  logic   dbg_req_i,
    input  logic   update_i,
    output logic   gnt_valid_o,
    output owner_e gnt_o
);

    owner_e last_q;
    owner_e last_d;

    always_comb begin
        gnt_valid_o = cpu_req_i | dbg_req_i;
        gnt_o       = OWN_CPU;
        if (cpu_req_i && dbg_req_i) begin
            // Under contention the requester that did not win last time goes.
            gnt_o = (last_q == OWN_CPU) ? OWN_DBG : OWN_CPU;
        end else if (dbg_req_i) begin
            gnt_o = OWN_DBG;
        end
        last_d = last_q;
        if (update_i && gnt_valid_o) begin
            last_d = gnt_o;
        end
    end

    // Reset value pretends debug won last, so the CPU is favoured first.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_q <= OWN_DBG;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter/sequencer for the single-ported data memory shared by the CPU MEM
// stage and the debug/load port. Each grant becomes a MEM_LAT-cycle access
// followed by a one-cycle DONE that returns data / acknowledges.
//   clk_i, rst_i           : clock, asynchronous active-low reset
//   start_i                : CPU run enable (gates CPU requests at arbitration)
//   cpu_*                  : CPU request port; cpu_stall_o freezes the pipeline
//   dbg_*                  : debug request port; dbg_ack_o pulses on completion
//   mem_*                  : memory interface (word-aligned address)
//   misalign_o             : sticky, set when a granted address was misaligned
//   stall_cnt_o            : saturating count of cpu_stall_o cycles
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_stall_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_ack_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              misalign_o,
    output logic [31:0]       stall_cnt_o
);

    state_e            state_q,     state_d;
    owner_e            owner_q,     owner_d;
    logic              we_q,        we_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic [LAT_W-1:0]  cnt_q,       cnt_d;
    logic [DATA_W-1:0] rdata_q,     rdata_d;
    logic              misalign_q,  misalign_d;
    logic [31:0]       stall_cnt_q, stall_cnt_d;

    logic              arb_valid;
    owner_e            arb_gnt;
    logic              arb_update;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              cpu_stall;

    // Grants are only taken in IDLE; the pointer moves with each grant.
    assign arb_update = (state_q == IDLE) && arb_valid;

    rr_arb2 u_rr_arb2 (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i & start_i),
        .dbg_req_i   (dbg_req_i),
        .update_i    (arb_update),
        .gnt_valid_o (arb_valid),
        .gnt_o       (arb_gnt)
    );

    always_comb begin
        sel_we    = cpu_we_i;
        sel_addr  = cpu_addr_i;
        sel_wdata = cpu_wdata_i;
        if (arb_gnt == OWN_DBG) begin
            sel_we    = dbg_we_i;
            sel_addr  = dbg_addr_i;
            sel_wdata = dbg_wdata_i;
        end
    end

    // The stall is purely combinational from cpu_req_i so the pipeline also
    // freezes while start_i holds the CPU out of arbitration.
    assign cpu_stall = cpu_req_i && !((state_q == DONE) && (owner_q == OWN_CPU));

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        misalign_d = misalign_q;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d = ACCESS;
                    owner_d = arb_gnt;
                    we_d    = sel_we;
                    addr_d  = {sel_addr[ADDR_W-1:2], 2'b00};
                    wdata_d = sel_wdata;
                    cnt_d   = LAT_W'(MEM_LAT - 1);
                    if (sel_addr[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // Memory data is valid in the last ACCESS cycle only.
                if (cnt_q == '0) begin
                    rdata_d = mem_rdata_i;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        stall_cnt_d = stall_cnt_q;
        if (cpu_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            owner_q     <= OWN_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            misalign_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            misalign_q  <= misalign_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // mem_en_o decodes the state register directly so reset drops it at once.
    assign mem_en_o    = (state_q == ACCESS);
    assign mem_we_o    = (state_q == ACCESS) && we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign cpu_rdata_o = rdata_q;
    assign dbg_rdata_o = rdata_q;
    assign dbg_ack_o   = (state_q == DONE) && (owner_q == OWN_DBG);
    assign cpu_stall_o = cpu_stall;
    assign misalign_o  = misalign_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule
